// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction fetch controller. Steps the PC generator one instruction at a
// time: requests a halfword from instruction memory at pc_in, pre-decodes the
// returned instruction for branch-class opcodes, tells the PC generator how to
// move (advance, branch, branch-and-link, return) and buffers the fetched
// instruction with its address in a 2-entry FIFO toward decode. An
// execute-stage redirect (jmp_valid) overrides everything: it flushes the
// FIFO, discards any outstanding memory response and loads the PC with
// jmp_target.
//
// Build option:
//   FETCH_PREDECODE_EN  defined   -> B (0xC), BL (0xD) and RET (0xE000) decode
//                       undefined -> br/link/pclr stay 0, offset stays 0 and
//                                    every fetch advances sequentially
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   pc_in                 current PC from the PC generator
//   pc_wen, br, link      advance PC (sequential / branch / branch-and-link)
//   offset                sign-extended branch offset in halfwords
//   pc_wr, data_out       load PC with redirect target
//   pclr                  return: PC <= LR
//   mem_req, mem_addr     read request / address toward instruction memory
//   mem_gnt               request accepted this cycle
//   mem_rvalid, mem_rdata read response
//   jmp_valid, jmp_target execute-stage redirect pulse and target
//   inst_valid/data/pc    FIFO head toward decode
//   inst_ready            decode pops the head when inst_valid & inst_ready
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc_in,
    output logic        pc_wen,
    output logic        br,
    output logic        link,
    output logic [15:0] offset,
    output logic        pc_wr,
    output logic [15:0] data_out,
    output logic        pclr,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    input  logic        jmp_valid,
    input  logic [15:0] jmp_target,
    output logic        inst_valid,
    output logic [15:0] inst_data,
    output logic [15:0] inst_pc,
    input  logic        inst_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_ADV,
        S_REDIR,
        S_SETTLE
    } state_t;

    typedef enum logic [1:0] {
        D_SEQ,
        D_B,
        D_BL,
        D_RET
    } dec_t;

    state_t          state_q;
    logic            discard_q;
    logic [15:0]     addr_q;
    logic            pc_wen_q, br_q, link_q, pclr_q, pc_wr_q, mem_req_q;
    logic [15:0]     offset_q, data_out_q;

    logic [15:0]     fdata_q [DEPTH];
    logic [15:0]     fpc_q   [DEPTH];
    logic [PW-1:0]   wp_q, rp_q;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            push, pop;
    dec_t            rd_dec;
    logic [15:0]     rd_off;

    // ---------------------------------------------------------------------
    // Pre-decode of the returning instruction
    // ---------------------------------------------------------------------
`ifdef FETCH_PREDECODE_EN
    always_comb begin
        rd_dec = D_SEQ;
        rd_off = {{4{mem_rdata[11]}}, mem_rdata[11:0]};
        case (mem_rdata[15:12])
            4'hC:    rd_dec = D_B;
            4'hD:    rd_dec = D_BL;
            4'hE:    rd_dec = (mem_rdata[11:0] == 12'h000) ? D_RET : D_SEQ;
            default: rd_dec = D_SEQ;
        endcase
    end
`else
    assign rd_dec = D_SEQ;
    assign rd_off = 16'h0000;
`endif

    // A redirect wins over a same-cycle push or pop; the response that
    // belongs to a flushed request never enters the FIFO.
    assign push = (state_q == S_RESP) && mem_rvalid && !discard_q && !jmp_valid;
    assign pop  = inst_ready && (cnt_q != '0) && !jmp_valid;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered PC-control and request outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            discard_q  <= 1'b0;
            addr_q     <= 16'h0000;
            pc_wen_q   <= 1'b0;
            br_q       <= 1'b0;
            link_q     <= 1'b0;
            pclr_q     <= 1'b0;
            pc_wr_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            offset_q   <= 16'h0000;
            data_out_q <= 16'h0000;
        end else begin
            // Every PC-control output is a single-cycle pulse.
            pc_wen_q   <= 1'b0;
            br_q       <= 1'b0;
            link_q     <= 1'b0;
            pclr_q     <= 1'b0;
            pc_wr_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            offset_q   <= 16'h0000;
            data_out_q <= 16'h0000;

            // The first response after a flushed grant is the stale one.
            if (mem_rvalid && discard_q)
                discard_q <= 1'b0;

            if (jmp_valid) begin
                state_q    <= S_REDIR;
                pc_wr_q    <= 1'b1;
                data_out_q <= jmp_target;
                // Granted but unanswered request: its response must be dropped.
                if ((state_q == S_REQ && mem_gnt) || (state_q == S_RESP && !mem_rvalid))
                    discard_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // In IDLE nothing is in flight, so the FIFO count alone
                        // decides; discard blocks until the stale data returns.
                        if (!discard_q && cnt_q < FULL) begin
                            state_q   <= S_REQ;
                            mem_req_q <= 1'b1;
                        end
                    end
                    S_REQ: begin
                        if (mem_gnt) begin
                            state_q <= S_RESP;
                            addr_q  <= pc_in;
                        end else begin
                            mem_req_q <= 1'b1;
                        end
                    end
                    S_RESP: begin
                        if (mem_rvalid) begin
                            state_q <= S_ADV;
                            case (rd_dec)
                                D_B: begin
                                    pc_wen_q <= 1'b1;
                                    br_q     <= 1'b1;
                                    offset_q <= rd_off;
                                end
                                D_BL: begin
                                    pc_wen_q <= 1'b1;
                                    br_q     <= 1'b1;
                                    link_q   <= 1'b1;
                                    offset_q <= rd_off;
                                end
                                D_RET:   pclr_q   <= 1'b1;
                                default: pc_wen_q <= 1'b1;
                            endcase
                        end
                    end
                    S_ADV:    state_q <= S_IDLE;
                    S_REDIR:  state_q <= S_SETTLE;
                    // PC generator ignores pc_wen right after pc_wr.
                    S_SETTLE: state_q <= S_IDLE;
                    default:  state_q <= S_IDLE;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // Instruction FIFO: control with reset, storage without
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || jmp_valid) begin
            cnt_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wp_q <= wp_q + PW'(1);
            if (pop)  rp_q <= rp_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fdata_q[wp_q] <= mem_rdata;
            fpc_q[wp_q]   <= addr_q;
        end
    end

    assign inst_valid = (cnt_q != '0);
    assign inst_data  = inst_valid ? fdata_q[rp_q] : 16'h0000;
    assign inst_pc    = inst_valid ? fpc_q[rp_q]   : 16'h0000;

    // mem_addr follows pc_in while requesting; pc_in is stable in REQ.
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_req_q ? pc_in : 16'h0000;

    assign pc_wen   = pc_wen_q;
    assign br       = br_q;
    assign link     = link_q;
    assign pclr     = pclr_q;
    assign offset   = offset_q;
    assign pc_wr    = pc_wr_q;
    assign data_out = data_out_q;

endmodule
